test_switch_led_ctrl: RTL and testbench
=======================================

Name: test_switch_led_ctrl

Overview:
Multi-channel successor to the single-bit test switch/LED logic in the opb_ext_bridge.
- Per channel: synchronises and debounces an active-low test switch and produces a one-cycle press event.
- Per channel: drives a test LED in one of four software-selected modes (follow switch, forced on, blink, pulse-stretch).
- A global lamp-test input forces every LED on.
- Mode bits come from bridge register bits; debounced state and press events are returned for register readback and interrupt use.

Parameters:
NUM_CH, 4, number of switch/LED channel pairs (1..16).
DB_CYCLES, 16, consecutive stable synchronised cycles required before sw_db changes (>=1).
BLINK_DIV, 1024, clk cycles per blink half-period (>=1); the blink period is 2*BLINK_DIV.
STRETCH_CYCLES, 256, clk cycles the LED stays on after a press event in stretch mode (>=1).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
sw_in  input  [0:NUM_CH-1]  raw test switches, 0 = pressed, asynchronous to clk.
led_mode  input  [0:2*NUM_CH-1]  mode per channel; channel i uses bits [2i:2i+1], where bit 2i is the MSB.
lamp_test  input  1  1 = force all LEDs on.
sw_db  output  [0:NUM_CH-1]  debounced switch level, 0 = pressed.
sw_press  output  [0:NUM_CH-1]  one-cycle pulse on each debounced press (sw_db 1->0).
test_led  output  [0:NUM_CH-1]  LED drive, 1 = on.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0:
  - test_led = all 1s (LEDs lit during reset, as on existing boards);
  - sw_db = all 1s; sw_press = all 0s;
  - synchroniser flops = 1; debounce and stretch counters = 0;
  - blink prescaler = 0; blink_phase = 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Synchroniser: two flops per channel; sync[i] lags sw_in[i] by 2 clk edges.
- Debounce, per channel, counter width sized to hold DB_CYCLES-1:
  - If sync[i] == sw_db[i]: the counter clears to 0.
  - Else, if counter == DB_CYCLES-1: sw_db[i] <= sync[i] and the counter clears.
  - Else: the counter increments.
  - Any glitch back to the sw_db value restarts the count.
  - A clean edge on sw_in reaches sw_db after exactly 2+DB_CYCLES edges.
- sw_press[i] = 1 for exactly the cycle in which sw_db[i] is first 0 after being 1. Releases (0->1) generate no pulse.
- Blink prescaler (shared by all channels):
  - Counts 0..BLINK_DIV-1 and wraps.
  - On the wrap edge blink_phase toggles, so the first toggle (to 0) occurs BLINK_DIV edges after reset release.
  - Free-running; independent of mode.
- Stretch counter, per channel, width sized to hold STRETCH_CYCLES:
  - On the edge where sw_press[i] is captured, it loads STRETCH_CYCLES; otherwise it decrements while nonzero.
  - A press while nonzero reloads it (retrigger); there is no accumulation.
  - Runs in all modes.
- LED, registered, updated every edge:
  - lamp_test=1 -> test_led[i]=1 for all i, with 1 cycle of latency.
  - Otherwise, by mode:
    - 00 follow: test_led[i] = ~sw_db[i] (legacy behaviour).
    - 01 forced on: test_led[i] = 1.
    - 10 blink: test_led[i] = blink_phase.
    - 11 stretch: test_led[i] = (stretch counter != 0).
- Mode change takes effect on the next edge. No counter is disturbed by a mode change.
- Simultaneous press and counter expiry: the reload wins.
- Reset asserted mid-operation: all state returns immediately to its reset values. The first debounce after release starts from sw_db=1.

Test Plan:
- Reset, then hold sw_in=all 1s: during reset test_led=1111 and sw_db=1111. After release with mode=all 00, test_led=0000 and sw_press never asserts.
- Clean press: DB_CYCLES=16, ch0 sw_in 1->0. sw_db[0] falls exactly 18 edges later; sw_press[0] is high for 1 cycle coincident with that fall; test_led[0]=1 one cycle after sw_db[0] falls.
- Bounce: ch1 sw_in toggles 0/1 every 5 cycles for 100 cycles, then stays 0. sw_db[1] stays 1 throughout the bounce and falls 18 edges after the final edge; exactly one sw_press[1] pulse occurs.
- Blink: BLINK_DIV=4, ch2 mode=10. test_led[2] shows period 8 cycles at 50% duty. Switching ch2 to 01 mid-period gives test_led[2]=1 on the next edge.
- Stretch: STRETCH_CYCLES=10, ch3 mode=11. A press gives test_led[3] high for 10 cycles. A second press debounced at counter=3 reloads it, for 10 more cycles from that point.
- Lamp test and reset: lamp_test=1 with all modes 00 gives test_led=1111 next edge. Asserting reset_n=0 mid-stretch gives test_led=1111 and stretch counters 0 immediately; after release test_led=0000.

Source files
------------

// File: rtl/test_switch_led_ctrl.sv
// Multi-channel test switch / LED controller: per-channel sync, debounce, press
// detect and LED mode mux, sharing one free-running blink prescaler.

module switch_led_ch #(
  parameter int DB_CYCLES      = 16,
  parameter int STRETCH_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_raw,
  input  logic [1:0] mode,
  input  logic       lamp_test,
  input  logic       blink_phase,
  output logic       sw_db,
  output logic       sw_press,
  output logic       test_led
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int STW = $clog2(STRETCH_CYCLES + 1);

  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt;
  logic [STW-1:0] st_cnt;
  logic           sync, db_fire, press_nxt;

  assign sync = sync_q[1];

  always_comb begin
    db_fire   = (sync != sw_db) && (db_cnt == DBW'(DB_CYCLES - 1));
    press_nxt = db_fire && !sync;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      db_cnt   <= '0;
      sw_db    <= 1'b1;
      sw_press <= 1'b0;
      st_cnt   <= '0;
      test_led <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], sw_raw};
      sw_press <= press_nxt;
      // any sample matching the current level restarts the stability count
      if (sync == sw_db)  db_cnt <= '0;
      else if (db_fire) begin
        sw_db  <= sync;
        db_cnt <= '0;
      end else            db_cnt <= db_cnt + 1'b1;
      // a new press always reloads, even on the cycle the count would expire
      if (press_nxt)           st_cnt <= STW'(STRETCH_CYCLES);
      else if (st_cnt != '0)   st_cnt <= st_cnt - 1'b1;
      if (lamp_test) test_led <= 1'b1;
      else begin
        case (mode)
          2'b00:   test_led <= ~sw_db;
          2'b01:   test_led <= 1'b1;
          2'b10:   test_led <= blink_phase;
          default: test_led <= (st_cnt != '0);
        endcase
      end
    end
  end
endmodule

module test_switch_led_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int DB_CYCLES      = 16,
  parameter int BLINK_DIV      = 1024,
  parameter int STRETCH_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [0:NUM_CH-1]   sw_in,
  input  logic [0:2*NUM_CH-1] led_mode,
  input  logic                lamp_test,
  output logic [0:NUM_CH-1]   sw_db,
  output logic [0:NUM_CH-1]   sw_press,
  output logic [0:NUM_CH-1]   test_led
);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // channel i takes mode bits [2i:2i+1], bit 2i being the MSB
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    switch_led_ch #(
      .DB_CYCLES      (DB_CYCLES),
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_raw      (sw_in[i]),
      .mode        (led_mode[2*i +: 2]),
      .lamp_test   (lamp_test),
      .blink_phase (blink_phase),
      .sw_db       (sw_db[i]),
      .sw_press    (sw_press[i]),
      .test_led    (test_led[i])
    );
  end
endmodule

// File: tb/tb_test_switch_led_ctrl.sv
// Bench for test_switch_led_ctrl: vector table, directed corner sequences and
// random stimulus checked every cycle against a history-based reference model.

module tb_test_switch_led_ctrl;
  localparam int NC = 4, DB = 16, BD = 4, ST = 40;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [0:NC-1]     sw_in = '1;
  logic [0:2*NC-1]   led_mode = '0;
  logic              lamp_test = 1'b0;
  logic [0:NC-1]     sw_db, sw_press, test_led;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  test_switch_led_ctrl #(
    .NUM_CH(NC), .DB_CYCLES(DB), .BLINK_DIV(BD), .STRETCH_CYCLES(ST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .led_mode(led_mode),
    .lamp_test(lamp_test), .sw_db(sw_db), .sw_press(sw_press), .test_led(test_led)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw input history, edge count since reset, last press edge
  logic [63:0]   h [NC];
  int            lp [NC];
  int            n;
  logic [0:NC-1] m_db, m_press, m_led;

  task automatic m_reset();
    n = 0; m_db = '1; m_press = '0; m_led = '1;
    for (int ch = 0; ch < NC; ch++) begin h[ch] = '1; lp[ch] = -1000; end
  endtask

  task automatic m_step();
    n++;
    for (int ch = 0; ch < NC; ch++) begin
      logic [1:0] md;
      logic       l, flip;
      md = {led_mode[2*ch], led_mode[2*ch+1]};
      case (md)
        2'b00:   l = ~m_db[ch];
        2'b01:   l = 1'b1;
        2'b10:   l = (((n - 1) / BD) % 2 == 0);
        default: l = ((n - 1 - lp[ch]) < ST);
      endcase
      if (lamp_test) l = 1'b1;
      m_led[ch] = l;
      // level changes once the last DB synchronised samples all disagree with it
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) if (h[ch][j] == m_db[ch]) flip = 1'b0;
      m_press[ch] = flip & m_db[ch];
      if (flip) m_db[ch] = ~m_db[ch];
      if (m_press[ch]) lp[ch] = n;
      h[ch] = {h[ch][62:0], sw_in[ch]};
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else          m_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_db", sw_db, m_db);
      chk("model_press", sw_press, m_press);
      chk("model_led", test_led, m_led);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [0:NC-1]   sw;
    logic [0:2*NC-1] mode;
    logic            lamp;
    int              hold;
    logic [0:NC-1]   exp_led;
    logic [0:NC-1]   exp_db;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   k, k2, bad, presses, t;
    logic s [24];

    vecs[0] = '{4'b1111, 8'h00, 1'b0, 5,  4'b0000, 4'b1111};
    vecs[1] = '{4'b1111, 8'h00, 1'b1, 1,  4'b1111, 4'b1111};
    vecs[2] = '{4'b1111, 8'h55, 1'b0, 2,  4'b1111, 4'b1111};
    vecs[3] = '{4'b0000, 8'h00, 1'b0, 20, 4'b1111, 4'b0000};
    vecs[4] = '{4'b1111, 8'h00, 1'b0, 20, 4'b0000, 4'b1111};
    vecs[5] = '{4'b1111, 8'hFF, 1'b0, 2,  4'b1111, 4'b1111};
    vecs[6] = '{4'b1111, 8'hFF, 1'b0, 20, 4'b0000, 4'b1111};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_led", test_led, 4'b1111);
    chk("rst_db", sw_db, 4'b1111);
    chk("rst_press", sw_press, 4'b0000);
    chk_en = 1'b1;
    #2 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sw_in = vecs[i].sw; led_mode = vecs[i].mode; lamp_test = vecs[i].lamp;
      repeat (vecs[i].hold) @(negedge clk);
      chk($sformatf("vec%0d_led", i), test_led, vecs[i].exp_led);
      chk($sformatf("vec%0d_db", i), sw_db, vecs[i].exp_db);
    end

    // clean press on ch0
    sw_in = 4'b0111; led_mode = '0; lamp_test = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (sw_db[0] && k < 40);
    chk("press_latency", k, 18);
    chk("press_pulse", sw_press[0], 1'b1);
    chk("led_at_fall", test_led[0], 1'b0);
    @(negedge clk);
    chk("press_one_cycle", sw_press[0], 1'b0);
    chk("led_follow", test_led[0], 1'b1);
    sw_in = '1;
    repeat (25) @(negedge clk);

    // bounce on ch1
    presses = 0; bad = 0;
    for (int seg = 0; seg < 20; seg++) begin
      sw_in[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (sw_press[1]) presses++;
        if (!sw_db[1]) bad++;
      end
    end
    sw_in[1] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; if (sw_press[1]) presses++; end while (sw_db[1] && k < 40);
    repeat (3) begin @(negedge clk); if (sw_press[1]) presses++; end
    chk("bounce_stable", bad, 0);
    chk("bounce_latency", k, 18);
    chk("bounce_presses", presses, 1);
    sw_in = '1;
    repeat (25) @(negedge clk);

    // blink on ch2
    led_mode = 8'h08;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 24; j++) begin @(negedge clk); s[j] = test_led[2]; end
    t = -1;
    for (int j = 1; j <= 8; j++) if (t < 0 && s[j] != s[0]) t = j;
    chk("blink_toggles", (t > 0), 1'b1);
    if (t < 0) t = 0;
    bad = 0;
    for (int j = 0; j < 16; j++)
      if (s[t+j] !== (((j % 8) < 4) ? s[t] : ~s[t])) bad++;
    chk("blink_wave", bad, 0);
    k = 0;
    while (test_led[2] && k < 10) begin @(negedge clk); k++; end
    led_mode = 8'h04;
    @(negedge clk);
    chk("blink_to_on", test_led[2], 1'b1);

    // stretch on ch3: single press
    led_mode = 8'h03; sw_in = 4'b1110;
    k = 0;
    do begin @(negedge clk); k++; end while (!sw_press[3] && k < 40);
    chk("st_press_latency", k, 18);
    sw_in = '1;
    chk("st_led_pre", test_led[3], 1'b0);
    bad = 0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (test_led[3] !== (j <= ST)) bad++;
    end
    chk("stretch_len", bad, 0);

    // stretch retrigger with counter at 3
    sw_in = 4'b1110;
    k = 0;
    do begin @(negedge clk); k++; end while (!sw_press[3] && k < 40);
    sw_in = '1;
    k2 = 0; bad = 0;
    for (int j = 1; j <= 85; j++) begin
      @(negedge clk);
      if (sw_press[3]) k2 = j;
      if (test_led[3] !== (j <= 78)) bad++;
      if (j == 20) sw_in[3] = 1'b0;
    end
    chk("reload_edge", k2, 38);
    chk("reload_len", bad, 0);
    sw_in = '1;
    repeat (25) @(negedge clk);

    // lamp test
    led_mode = '0; lamp_test = 1'b1;
    @(negedge clk);
    chk("lamp_on", test_led, 4'b1111);
    lamp_test = 1'b0;
    @(negedge clk);
    chk("lamp_off", test_led, 4'b0000);

    // reset mid-stretch
    led_mode = 8'hFF; sw_in = '0;
    k = 0;
    do begin @(negedge clk); k++; end while (!sw_press[0] && k < 40);
    repeat (3) @(negedge clk);
    chk("mid_st_led", test_led, 4'b1111);
    sw_in = '1;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_led", test_led, 4'b1111);
    chk("midrst_db", sw_db, 4'b1111);
    chk("midrst_press", sw_press, 4'b0000);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_stretch", test_led, 4'b0000);
    led_mode = '0;
    @(negedge clk);
    chk("post_rst_follow", test_led, 4'b0000);
    chk("post_rst_db", sw_db, 4'b1111);

    // random stimulus, checked by the model every cycle
    repeat (3000) begin
      @(negedge clk);
      for (int ch = 0; ch < NC; ch++)
        if ($urandom_range(0, 29) == 0) sw_in[ch] = ~sw_in[ch];
      if ($urandom_range(0, 49) == 0) led_mode = 8'($urandom);
      lamp_test = ($urandom_range(0, 63) == 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
